// File: rtl/i_instr_decode.sv
// Registered RV32I I-type field decoder: slices one instruction word per enabled
// cycle and flags the I-type class, shift-immediates and illegal field combinations.
module i_instr_decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] instr_word,
    output logic [11:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [6:0]  opcode,
    output logic [31:0] imm_sext,
    output logic [4:0]  shamt,
    output logic        is_itype,
    output logic        is_load,
    output logic        is_jalr,
    output logic        is_shift,
    output logic        illegal
);

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    logic [6:0] nx_opcode;
    logic [2:0] nx_funct3;
    logic [6:0] nx_funct7;
    logic       nx_is_itype;
    logic       nx_is_load;
    logic       nx_is_jalr;
    logic       nx_is_shift;
    logic       nx_illegal;

    // Classification only; the raw slices below are captured for every opcode.
    always_comb begin
        nx_opcode   = instr_word[6:0];
        nx_funct3   = instr_word[14:12];
        nx_funct7   = instr_word[31:25];
        nx_is_itype = 1'b0;
        nx_is_load  = 1'b0;
        nx_is_jalr  = 1'b0;
        nx_is_shift = 1'b0;
        nx_illegal  = 1'b0;
        case (nx_opcode)
            OP_IMM: begin
                nx_is_itype = 1'b1;
                if (nx_funct3 == 3'b001) begin
                    nx_is_shift = 1'b1;
                    nx_illegal  = (nx_funct7 != 7'b0000000);
                end else if (nx_funct3 == 3'b101) begin
                    nx_is_shift = 1'b1;
                    nx_illegal  = (nx_funct7 != 7'b0000000) && (nx_funct7 != 7'b0100000);
                end
            end
            LOAD: begin
                nx_is_itype = 1'b1;
                nx_is_load  = 1'b1;
                nx_illegal  = (nx_funct3 == 3'b011) || (nx_funct3 == 3'b110) ||
                              (nx_funct3 == 3'b111);
            end
            JALR: begin
                nx_is_itype = 1'b1;
                nx_is_jalr  = 1'b1;
                nx_illegal  = (nx_funct3 != 3'b000);
            end
            SYSTEM: begin
                nx_is_itype = 1'b1;
                nx_illegal  = (nx_funct3 == 3'b100);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm      <= '0;
            rs1      <= '0;
            rd       <= '0;
            funct3   <= '0;
            opcode   <= '0;
            imm_sext <= '0;
            shamt    <= '0;
            is_itype <= 1'b0;
            is_load  <= 1'b0;
            is_jalr  <= 1'b0;
            is_shift <= 1'b0;
            illegal  <= 1'b0;
        end else if (en) begin
            imm      <= instr_word[31:20];
            rs1      <= instr_word[19:15];
            rd       <= instr_word[11:7];
            funct3   <= nx_funct3;
            opcode   <= nx_opcode;
            imm_sext <= {{20{instr_word[31]}}, instr_word[31:20]};
            shamt    <= instr_word[24:20];
            is_itype <= nx_is_itype;
            is_load  <= nx_is_load;
            is_jalr  <= nx_is_jalr;
            is_shift <= nx_is_shift;
            illegal  <= nx_illegal;
        end
    end

endmodule

// File: tb/tb_i_instr_decode.sv
// Directed table-driven bench for i_instr_decode, plus enable-hold, latency and
// asynchronous-reset sequences.
module tb_i_instr_decode;

    typedef struct {
        logic [31:0] instr;
        logic [11:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  opcode;
        logic [31:0] imm_sext;
        logic [4:0]  shamt;
        logic        is_itype;
        logic        is_load;
        logic        is_jalr;
        logic        is_shift;
        logic        illegal;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] instr_word;
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  opcode;
    logic [31:0] imm_sext;
    logic [4:0]  shamt;
    logic        is_itype;
    logic        is_load;
    logic        is_jalr;
    logic        is_shift;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];
    vec_t zero_v;
    vec_t jalr_bad;
    vec_t last_v;

    i_instr_decode dut (
        .clk(clk), .rst_n(rst_n), .en(en), .instr_word(instr_word),
        .imm(imm), .rs1(rs1), .rd(rd), .funct3(funct3), .opcode(opcode),
        .imm_sext(imm_sext), .shamt(shamt), .is_itype(is_itype),
        .is_load(is_load), .is_jalr(is_jalr), .is_shift(is_shift),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", tag, field, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t e);
        chk(tag, "imm",      32'(imm),      32'(e.imm));
        chk(tag, "rs1",      32'(rs1),      32'(e.rs1));
        chk(tag, "rd",       32'(rd),       32'(e.rd));
        chk(tag, "funct3",   32'(funct3),   32'(e.funct3));
        chk(tag, "opcode",   32'(opcode),   32'(e.opcode));
        chk(tag, "imm_sext", imm_sext,      e.imm_sext);
        chk(tag, "shamt",    32'(shamt),    32'(e.shamt));
        chk(tag, "is_itype", 32'(is_itype), 32'(e.is_itype));
        chk(tag, "is_load",  32'(is_load),  32'(e.is_load));
        chk(tag, "is_jalr",  32'(is_jalr),  32'(e.is_jalr));
        chk(tag, "is_shift", 32'(is_shift), 32'(e.is_shift));
        chk(tag, "illegal",  32'(illegal),  32'(e.illegal));
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic apply(input logic [31:0] w, input logic e);
        @(negedge clk);
        instr_word = w;
        en = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                instr         imm     rs1 rd  f3 op      imm_sext      sh  it ld jr sh il
        zero_v   = '{32'h00000000, 12'h000, 0,  0,  0, 7'h00, 32'h00000000, 0,  0, 0, 0, 0, 0};
        jalr_bad = '{32'h000110E7, 12'h000, 2,  1,  1, 7'h67, 32'h00000000, 0,  1, 0, 1, 0, 1};
        vecs.push_back('{32'h00000000, 12'h000, 0,  0,  0, 7'h00, 32'h00000000, 0,  0, 0, 0, 0, 0});
        vecs.push_back('{32'h234AB600, 12'h234, 21, 12, 3, 7'h00, 32'h00000234, 20, 0, 0, 0, 0, 0});
        vecs.push_back('{32'h405A8333, 12'h405, 21, 6,  0, 7'h33, 32'h00000405, 5,  0, 0, 0, 0, 0});
        vecs.push_back('{32'hFFF30293, 12'hFFF, 6,  5,  0, 7'h13, 32'hFFFFFFFF, 31, 1, 0, 0, 0, 0});
        vecs.push_back('{32'h40315093, 12'h403, 2,  1,  5, 7'h13, 32'h00000403, 3,  1, 0, 0, 1, 0});
        vecs.push_back('{32'h40311093, 12'h403, 2,  1,  1, 7'h13, 32'h00000403, 3,  1, 0, 0, 1, 1});
        vecs.push_back('{32'h00311093, 12'h003, 2,  1,  1, 7'h13, 32'h00000003, 3,  1, 0, 0, 1, 0});
        vecs.push_back('{32'h00315093, 12'h003, 2,  1,  5, 7'h13, 32'h00000003, 3,  1, 0, 0, 1, 0});
        vecs.push_back('{32'h42315093, 12'h423, 2,  1,  5, 7'h13, 32'h00000423, 3,  1, 0, 0, 1, 1});
        vecs.push_back('{32'h7FF17093, 12'h7FF, 2,  1,  7, 7'h13, 32'h000007FF, 31, 1, 0, 0, 0, 0});
        vecs.push_back('{32'h80016093, 12'h800, 2,  1,  6, 7'h13, 32'hFFFFF800, 0,  1, 0, 0, 0, 0});
        vecs.push_back('{32'hFFC42183, 12'hFFC, 8,  3,  2, 7'h03, 32'hFFFFFFFC, 28, 1, 1, 0, 0, 0});
        vecs.push_back('{32'hFFC43183, 12'hFFC, 8,  3,  3, 7'h03, 32'hFFFFFFFC, 28, 1, 1, 0, 0, 1});
        vecs.push_back('{32'hFFC44183, 12'hFFC, 8,  3,  4, 7'h03, 32'hFFFFFFFC, 28, 1, 1, 0, 0, 0});
        vecs.push_back('{32'hFFC46183, 12'hFFC, 8,  3,  6, 7'h03, 32'hFFFFFFFC, 28, 1, 1, 0, 0, 1});
        vecs.push_back('{32'hFFC47183, 12'hFFC, 8,  3,  7, 7'h03, 32'hFFFFFFFC, 28, 1, 1, 0, 0, 1});
        vecs.push_back('{32'h00008067, 12'h000, 1,  0,  0, 7'h67, 32'h00000000, 0,  1, 0, 1, 0, 0});
        vecs.push_back('{32'h00000073, 12'h000, 0,  0,  0, 7'h73, 32'h00000000, 0,  1, 0, 0, 0, 0});
        vecs.push_back('{32'h00004073, 12'h000, 0,  0,  4, 7'h73, 32'h00000000, 0,  1, 0, 0, 0, 1});
        vecs.push_back('{32'h00003023, 12'h000, 0,  0,  3, 7'h23, 32'h00000000, 0,  0, 0, 0, 0, 0});
        vecs.push_back('{32'h00001063, 12'h000, 0,  0,  1, 7'h63, 32'h00000000, 0,  0, 0, 0, 0, 0});

        // Load a nonzero decode, then pull reset mid-cycle: outputs clear at once.
        rst_n = 1'b1;
        en = 1'b0;
        instr_word = '0;
        apply(32'hFFF30293, 1'b1);
        check_all("pre_reset", vecs[3]);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", zero_v);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].instr, 1'b1);
            check_all($sformatf("vec%0d", i), vecs[i]);
        end
        last_v = vecs[vecs.size() - 1];

        // en low: instr_word changes must not reach the outputs.
        apply(jalr_bad.instr, 1'b0);
        apply(32'hFFFFFFFF, 1'b0);
        apply(jalr_bad.instr, 1'b0);
        check_all("hold_en0", last_v);

        // One edge with en high brings in the held-back JALR word.
        apply(jalr_bad.instr, 1'b1);
        check_all("jalr_latency", jalr_bad);

        // Reset mid-stream with en high: nothing captured while held low.
        @(negedge clk);
        instr_word = 32'hFFF30293;
        en = 1'b1;
        rst_n = 1'b0;
        #1;
        check_all("mid_reset", zero_v);
        @(posedge clk);
        #1;
        check_all("reset_held", zero_v);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_reset_en0", zero_v);
        apply(32'hFFF30293, 1'b1);
        check_all("first_capture", vecs[3]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
